qspi_tx_shifter: RTL and testbench

//   Downstream consumer of the AXI-read TX FIFO. Pops 32-bit words (FWFT FIFO)
//   and serialises them onto the QSPI data lanes in single/dual/quad mode,

---
 rtl/qspi_tx_shifter_pkg.sv | 58 +++++
 rtl/qspi_tx_shifter_sck_gen.sv | 53 +++++
 rtl/qspi_tx_shifter.sv | 138 +++++++++++++
 tb/tb_qspi_tx_shifter.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/qspi_tx_shifter_pkg.sv
// Shared lane-mode constants, FSM encoding and bit-group helpers for the QSPI TX shifter.
package qspi_pkg;

    localparam logic [1:0] LANE_SINGLE = 2'b00;
    localparam logic [1:0] LANE_DUAL   = 2'b01;
    localparam logic [1:0] LANE_QUAD   = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_FIN   = 2'd3
    } qspi_state_e;

    function automatic logic [2:0] bits_per_sck(input logic [1:0] mode);
        case (mode)
            LANE_DUAL: bits_per_sck = 3'd2;
            LANE_QUAD: bits_per_sck = 3'd4;
            default:   bits_per_sck = 3'd1;
        endcase
    endfunction

    // Index of the last bit-group within a byte (groups per byte minus one).
    function automatic logic [2:0] last_group(input logic [1:0] mode);
        case (mode)
            LANE_DUAL: last_group = 3'd3;
            LANE_QUAD: last_group = 3'd1;
            default:   last_group = 3'd7;
        endcase
    endfunction

    function automatic logic [3:0] lane_oe(input logic [1:0] mode);
        case (mode)
            LANE_DUAL: lane_oe = 4'b0011;
            LANE_QUAD: lane_oe = 4'b1111;
            default:   lane_oe = 4'b0001;
        endcase
    endfunction

    // MSB-first group grp of byte byte_idx; unused lanes read as 0.
    function automatic logic [3:0] bit_group(input logic [31:0] word,
                                             input logic [1:0]  byte_idx,
                                             input logic [2:0]  grp,
                                             input logic [1:0]  mode);
        logic [7:0] b;
        logic [7:0] sh;
        logic [2:0] amt;
        b   = word[{byte_idx, 3'b000} +: 8];
        amt = grp * bits_per_sck(mode);
        sh  = b << amt;
        case (mode)
            LANE_QUAD: bit_group = sh[7:4];
            LANE_DUAL: bit_group = {2'b00, sh[7:6]};
            default:   bit_group = {3'b000, sh[7]};
        endcase
    endfunction

endpackage

// File: rtl/qspi_tx_shifter_sck_gen.sv
// SCK generator: CLK_DIV clk cycles per half-period, with one-cycle rise/fall strobes.
module qspi_sck_gen #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic en_i,
    input  logic clr_i,
    output logic sck_o,
    output logic rise_tick_o,
    output logic fall_tick_o
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          sck_q, sck_d;
    logic          half_done;

    assign half_done = (cnt_q == CW'(CLK_DIV - 1));

    always_comb begin
        cnt_d = cnt_q;
        sck_d = sck_q;
        if (clr_i) begin
            cnt_d = '0;
            sck_d = 1'b0;
        end else if (en_i) begin
            if (half_done) begin
                cnt_d = '0;
                sck_d = ~sck_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
            sck_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            sck_q <= sck_d;
        end
    end

    // Strobes fire in the cycle whose clock edge performs the toggle.
    assign rise_tick_o = en_i && !clr_i && half_done && !sck_q;
    assign fall_tick_o = en_i && !clr_i && half_done &&  sck_q;
    assign sck_o       = sck_q;

endmodule

// File: rtl/qspi_tx_shifter.sv
// Pops 32-bit words from an FWFT FIFO and serialises them onto 1/2/4 QSPI lanes, SPI mode 0.
module qspi_tx_shifter
    import qspi_pkg::*;
#(
    parameter int CLK_DIV = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] byte_count,
    input  logic [1:0]  lane_mode,
    input  logic [31:0] fifo_dout,
    input  logic        fifo_empty,
    output logic        fifo_rd_en,
    output logic        sck,
    output logic [3:0]  io_out,
    output logic [3:0]  io_oe,
    output logic        busy,
    output logic        done,
    output logic        stall,
    output qspi_state_e dbg_state
);

    qspi_state_e state_q, state_d;
    logic [15:0] remaining_q, remaining_d;
    logic [1:0]  mode_q, mode_d;
    logic [31:0] shreg_q, shreg_d;
    logic [1:0]  byte_idx_q, byte_idx_d;
    logic [2:0]  grp_q, grp_d;
    logic [3:0]  io_out_q, io_out_d;
    logic        sent_q, sent_d;
    logic        rise_tick, fall_tick;

    qspi_sck_gen #(.CLK_DIV(CLK_DIV)) u_sck_gen (
        .clk         (clk),
        .reset       (reset),
        .en_i        (state_q == ST_SHIFT),
        .clr_i       (state_q != ST_SHIFT),
        .sck_o       (sck),
        .rise_tick_o (rise_tick),
        .fall_tick_o (fall_tick)
    );

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        mode_d      = mode_q;
        shreg_d     = shreg_q;
        byte_idx_d  = byte_idx_q;
        grp_d       = grp_q;
        io_out_d    = io_out_q;
        sent_d      = sent_q;
        fifo_rd_en  = 1'b0;
        stall       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    remaining_d = byte_count;
                    mode_d      = (lane_mode == 2'b11) ? LANE_SINGLE : lane_mode;
                    sent_d      = 1'b0;
                    io_out_d    = 4'b0000;
                    state_d     = (byte_count == 16'd0) ? ST_FIN : ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (!fifo_empty) begin
                    fifo_rd_en = 1'b1;
                    shreg_d    = fifo_dout;
                    byte_idx_d = 2'd0;
                    grp_d      = 3'd0;
                    io_out_d   = bit_group(fifo_dout, 2'd0, 3'd0, mode_q);
                    state_d    = ST_SHIFT;
                end else begin
                    // An empty FIFO before the first word is just start-up latency.
                    stall = sent_q;
                end
            end
            ST_SHIFT: begin
                if (fall_tick) begin
                    if (grp_q == last_group(mode_q)) begin
                        remaining_d = remaining_q - 16'd1;
                        if (remaining_q == 16'd1) begin
                            state_d = ST_FIN;
                        end else if (byte_idx_q == 2'd3) begin
                            sent_d  = 1'b1;
                            state_d = ST_LOAD;
                        end else begin
                            byte_idx_d = byte_idx_q + 2'd1;
                            grp_d      = 3'd0;
                            io_out_d   = bit_group(shreg_q, byte_idx_q + 2'd1, 3'd0, mode_q);
                        end
                    end else begin
                        grp_d    = grp_q + 3'd1;
                        io_out_d = bit_group(shreg_q, byte_idx_q, grp_q + 3'd1, mode_q);
                    end
                end
            end
            ST_FIN: begin
                io_out_d = 4'b0000;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            remaining_q <= 16'd0;
            mode_q      <= LANE_SINGLE;
            shreg_q     <= 32'd0;
            byte_idx_q  <= 2'd0;
            grp_q       <= 3'd0;
            io_out_q    <= 4'b0000;
            sent_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            mode_q      <= mode_d;
            shreg_q     <= shreg_d;
            byte_idx_q  <= byte_idx_d;
            grp_q       <= grp_d;
            io_out_q    <= io_out_d;
            sent_q      <= sent_d;
        end
    end

    assign io_out    = io_out_q;
    assign io_oe     = (state_q == ST_LOAD || state_q == ST_SHIFT) ? lane_oe(mode_q) : 4'b0000;
    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_FIN);
    assign dbg_state = state_q;

    // rise_tick is informational only: data never changes on the rising edge.
    logic unused_rise;
    assign unused_rise = rise_tick;

endmodule

// File: tb/tb_qspi_tx_shifter.sv
// Self-checking bench for qspi_tx_shifter: vector table plus hand-written corner sequences.
module tb_qspi_tx_shifter;
    import qspi_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [15:0] byte_count = 16'd0;
    logic [1:0]  lane_mode = 2'b00;
    logic [31:0] fifo_dout = 32'd0;
    logic        fifo_empty = 1'b1;
    logic        fifo_rd_en;
    logic        sck;
    logic [3:0]  io_out;
    logic [3:0]  io_oe;
    logic        busy;
    logic        done;
    logic        stall;
    qspi_state_e dbg_state;

    qspi_tx_shifter #(.CLK_DIV(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .byte_count (byte_count),
        .lane_mode  (lane_mode),
        .fifo_dout  (fifo_dout),
        .fifo_empty (fifo_empty),
        .fifo_rd_en (fifo_rd_en),
        .sck        (sck),
        .io_out     (io_out),
        .io_oe      (io_oe),
        .busy       (busy),
        .done       (done),
        .stall      (stall),
        .dbg_state  (dbg_state)
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    int          rises = 0;
    int          pops  = 0;
    int          dones = 0;
    logic        sck_prev = 1'b0;
    logic [7:0]  exp_q[$];
    logic [31:0] fifo_q[$];

    typedef struct {
        logic [1:0]  mode;
        logic [15:0] count;
        logic [31:0] w0;
        logic [31:0] w1;
        int          exp_rises;
        int          exp_pops;
        bit          restart;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: every SCK rise must present the next expected {io_oe, io_out}.
    always @(negedge clk) begin
        if (done) dones++;
        if (sck && !sck_prev) begin
            rises++;
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL rise_extra: got %0h expected no rise", {io_oe, io_out});
            end else begin
                check("rise_data", {24'd0, io_oe, io_out}, {24'd0, exp_q.pop_front()});
            end
        end
        sck_prev = sck;
    end

    // FWFT FIFO model.
    always @(posedge clk) begin
        logic [31:0] dummy;
        if (fifo_rd_en && fifo_q.size() > 0) begin
            dummy = fifo_q.pop_front();
            pops++;
        end
        #1;
        fifo_empty = (fifo_q.size() == 0);
        fifo_dout  = (fifo_q.size() > 0) ? fifo_q[0] : 32'd0;
    end

    task automatic push_expected(input logic [1:0] mode, input int count,
                                 input logic [31:0] w0, input logic [31:0] w1);
        logic [31:0] w;
        logic [7:0]  b;
        logic [3:0]  oe;
        oe = (mode == 2'b01) ? 4'b0011 : (mode == 2'b10) ? 4'b1111 : 4'b0001;
        for (int k = 0; k < count; k++) begin
            w = (k < 4) ? w0 : w1;
            b = w[(k % 4) * 8 +: 8];
            case (mode)
                2'b10: begin
                    exp_q.push_back({oe, b[7:4]});
                    exp_q.push_back({oe, b[3:0]});
                end
                2'b01: for (int j = 7; j > 0; j -= 2) exp_q.push_back({oe, 2'b00, b[j], b[j-1]});
                default: for (int j = 7; j >= 0; j--) exp_q.push_back({oe, 3'b000, b[j]});
            endcase
        end
    endtask

    task automatic wait_done(input string name, input int budget);
        int c;
        c = 0;
        while (dones == 0 && c < budget) begin
            @(negedge clk);
            c++;
        end
        if (dones == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL %s_timeout: got no done expected done within %0d cycles", name, budget);
        end
    endtask

    task automatic pulse_start(input logic [15:0] cnt, input logic [1:0] mode);
        @(negedge clk);
        start      = 1'b1;
        byte_count = cnt;
        lane_mode  = mode;
        @(negedge clk);
        start      = 1'b0;
    endtask

    task automatic check_idle(input string name);
        check({name, "_busy"}, 32'(busy), 32'd0);
        check({name, "_sck"},  32'(sck), 32'd0);
        check({name, "_oe"},   32'(io_oe), 32'd0);
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        rises = 0;
        pops  = 0;
        dones = 0;
        fifo_q.push_back(v.w0);
        if (v.count > 16'd4) fifo_q.push_back(v.w1);
        push_expected(v.mode, int'(v.count), v.w0, v.w1);
        pulse_start(v.count, v.mode);
        if (v.restart) begin
            // A start while busy must not disturb the payload in flight.
            repeat (10) @(negedge clk);
            check($sformatf("vec%0d_busy_mid", idx), 32'(busy), 32'd1);
            pulse_start(16'd1, 2'b10);
        end
        wait_done($sformatf("vec%0d", idx), 3000);
        repeat (3) @(negedge clk);
        check($sformatf("vec%0d_rises", idx), rises, v.exp_rises);
        check($sformatf("vec%0d_pops", idx), pops, v.exp_pops);
        check($sformatf("vec%0d_dones", idx), dones, 32'd1);
        check($sformatf("vec%0d_leftover", idx), exp_q.size(), 32'd0);
        check_idle($sformatf("vec%0d_end", idx));
    endtask

    initial begin
        int c;
        vecs[0] = '{2'b00, 16'd4, 32'hA53C0F81, 32'h0,        32, 1, 1'b0};
        vecs[1] = '{2'b10, 16'd8, 32'h76543210, 32'hFEDCBA98, 16, 2, 1'b0};
        vecs[2] = '{2'b01, 16'd5, 32'h44332211, 32'h000000AA, 20, 2, 1'b0};
        vecs[3] = '{2'b11, 16'd3, 32'h00C35AF0, 32'h0,        24, 1, 1'b0};
        vecs[4] = '{2'b10, 16'd6, 32'h89ABCDEF, 32'h00003C12, 12, 2, 1'b1};

        // Reset state
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_idle("reset");
        check("reset_io_out", 32'(io_out), 32'd0);
        check("reset_done",   32'(done), 32'd0);
        check("reset_stall",  32'(stall), 32'd0);
        check("reset_rd_en",  32'(fifo_rd_en), 32'd0);
        check("reset_state",  32'(dbg_state), 32'(ST_IDLE));

        for (int i = 0; i < 5; i++) run_vec(i, vecs[i]);

        // Zero-length payload: done one cycle after start, nothing popped or clocked.
        rises = 0; pops = 0; dones = 0;
        fifo_q.push_back(32'hDEADBEEF);
        @(negedge clk);
        start = 1'b1; byte_count = 16'd0; lane_mode = 2'b00;
        @(negedge clk);
        start = 1'b0;
        check("zero_done", 32'(done), 32'd1);
        check("zero_rd_en", 32'(fifo_rd_en), 32'd0);
        @(negedge clk);
        check("zero_done_drop", 32'(done), 32'd0);
        check("zero_busy_drop", 32'(busy), 32'd0);
        repeat (3) @(negedge clk);
        check("zero_pops", pops, 32'd0);
        check("zero_rises", rises, 32'd0);
        check("zero_dones", dones, 32'd1);
        fifo_q.delete();
        repeat (2) @(negedge clk);

        // Underrun: no stall before the first word, stall after word 1 until word 2 arrives.
        rises = 0; pops = 0; dones = 0;
        push_expected(2'b10, 8, 32'h76543210, 32'hFEDCBA98);
        pulse_start(16'd8, 2'b10);
        repeat (5) begin
            check("pre_first_stall", 32'(stall), 32'd0);
            check("pre_first_busy", 32'(busy), 32'd1);
            @(negedge clk);
        end
        fifo_q.push_back(32'h76543210);
        c = 0;
        while (!stall && c < 500) begin
            @(negedge clk);
            c++;
        end
        check("stall_reached", 32'(stall), 32'd1);
        check("stall_pops", pops, 32'd1);
        check("stall_rises", rises, 32'd8);
        repeat (20) begin
            check("stall_hold", 32'(stall), 32'd1);
            check("stall_sck", 32'(sck), 32'd0);
            check("stall_rd_en", 32'(fifo_rd_en), 32'd0);
            check("stall_io_held", 32'(io_out), 32'h6);
            @(negedge clk);
        end
        fifo_q.push_back(32'hFEDCBA98);
        wait_done("underrun", 3000);
        repeat (3) @(negedge clk);
        check("underrun_rises", rises, 32'd16);
        check("underrun_pops", pops, 32'd2);
        check("underrun_dones", dones, 32'd1);
        check("underrun_leftover", exp_q.size(), 32'd0);
        check("underrun_stall_end", 32'(stall), 32'd0);

        // Reset mid-SHIFT: immediate return to idle values, no done pulse.
        rises = 0; pops = 0; dones = 0;
        fifo_q.push_back(32'hA53C0F81);
        push_expected(2'b00, 4, 32'hA53C0F81, 32'h0);
        pulse_start(16'd4, 2'b00);
        c = 0;
        while (rises < 5 && c < 500) begin
            @(negedge clk);
            c++;
        end
        check("midreset_reached", rises, 32'd5);
        reset = 1'b1;
        @(negedge clk);
        check_idle("midreset");
        check("midreset_done", 32'(done), 32'd0);
        check("midreset_stall", 32'(stall), 32'd0);
        reset = 1'b0;
        exp_q.delete();
        fifo_q.delete();
        repeat (5) @(negedge clk);
        check("midreset_no_done", dones, 32'd0);
        check("midreset_no_rise", rises, 32'd5);
        run_vec(5, vecs[0]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
